axi_read_arbiter_2x1: RTL and testbench

- Read-side interconnect stage between two AXI3-style read masters (1-bit ARID) and one read slave (2-bit ARID).
- Arbitrates AR requests from master 0 and master 1, registers the winner, and prefixes the master index onto ARID.
- Routes R beats back to the master selected by RID[1], through a one-entry R buffer.
- Per-master outstanding-burst counters throttle requests.

---
 rtl/axi_read_arbiter_2x1.sv | 198 +++++++++++++++++++
 tb/tb_axi_read_arbiter_2x1.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_arbiter_2x1.sv
// Two-master to one-slave AXI3 read interconnect stage: AR arbitration with ARID prefixing,
// one-entry R return buffer routed on RID[1], per-master outstanding-burst throttling.
// Optional macro ARB_FIXED_PRIORITY_EN selects fixed priority (master 0 first) instead of round-robin.
module axi_read_arbiter_2x1 #(
  parameter int BUSWIDTH  = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic                ACLK,
  input  logic                ARESET,
  // Master 0 AR
  input  logic                m0_arid,
  input  logic [BUSWIDTH+16:0] m0_arpay,
  input  logic                m0_arvalid,
  output logic                m0_arready,
  // Master 1 AR
  input  logic                m1_arid,
  input  logic [BUSWIDTH+16:0] m1_arpay,
  input  logic                m1_arvalid,
  output logic                m1_arready,
  // Slave AR
  output logic [1:0]          s_arid,
  output logic [BUSWIDTH+16:0] s_arpay,
  output logic                s_arvalid,
  input  logic                s_arready,
  // Slave R
  input  logic [1:0]          s_rid,
  input  logic [BUSWIDTH+2:0] s_rpay,
  input  logic                s_rvalid,
  output logic                s_rready,
  // Master 0 R
  output logic                m0_rid,
  output logic [BUSWIDTH+2:0] m0_rpay,
  output logic                m0_rvalid,
  input  logic                m0_rready,
  // Master 1 R
  output logic                m1_rid,
  output logic [BUSWIDTH+2:0] m1_rpay,
  output logic                m1_rvalid,
  input  logic                m1_rready
);

  localparam int AW = BUSWIDTH + 17;
  localparam int RW = BUSWIDTH + 3;
  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTST);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ar_state_t;

  ar_state_t       r_state;
  ar_state_t       w_state_nxt;
  logic [1:0]      r_arid;
  logic [AW-1:0]   r_arpay;
  logic            r_arvalid;
  logic [3:0]      r_cnt0;
  logic [3:0]      r_cnt1;
`ifndef ARB_FIXED_PRIORITY_EN
  logic            r_last_grant;
`endif

  logic            r_rfull;
  logic [1:0]      r_rid;
  logic [RW-1:0]   r_rpay;

  logic            w_elig0;
  logic            w_elig1;
  logic            w_grant_valid;
  logic            w_grant_idx;
  logic            w_s_rhs;
  logic            w_m_rhs;
  logic            w_inc0;
  logic            w_inc1;
  logic            w_dec0;
  logic            w_dec1;

  // Saturating counter step; simultaneous increment and decrement cancel out.
  function automatic logic [3:0] cnt_next(input logic [3:0] cnt, input logic inc, input logic dec);
    logic [3:0] nxt;
    nxt = cnt;
    if (inc && !dec) begin
      nxt = cnt + 4'd1;
    end else if (dec && !inc && (cnt != 4'd0)) begin
      nxt = cnt - 4'd1;
    end
    return nxt;
  endfunction

  assign w_elig0 = m0_arvalid && (r_cnt0 < MAX_CNT);
  assign w_elig1 = m1_arvalid && (r_cnt1 < MAX_CNT);

  // AR arbitration and next state
  always_comb begin
    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    w_state_nxt   = r_state;
    w_grant_valid = 1'b0;
    w_grant_idx   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!ARESET && (w_elig0 || w_elig1)) begin
          w_grant_valid = 1'b1;
`ifdef ARB_FIXED_PRIORITY_EN
          w_grant_idx   = !w_elig0;
`else
          if (w_elig0 && w_elig1) begin
            w_grant_idx = !r_last_grant;
          end else begin
            w_grant_idx = w_elig1;
          end
`endif
          w_state_nxt   = ST_SEND;
        end
      end
      ST_SEND: begin
        if (s_arready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign m0_arready = w_grant_valid && !w_grant_idx;
  assign m1_arready = w_grant_valid &&  w_grant_idx;

  // AR state and registered winner
  always_ff @(posedge ACLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (ARESET) begin
      r_state   <= ST_IDLE;
      r_arid    <= '0;
      r_arpay   <= '0;
      r_arvalid <= 1'b0;
`ifndef ARB_FIXED_PRIORITY_EN
      r_last_grant <= 1'b1;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_valid) begin
        r_arid    <= {w_grant_idx, (w_grant_idx ? m1_arid : m0_arid)};
        r_arpay   <= w_grant_idx ? m1_arpay : m0_arpay;
        r_arvalid <= 1'b1;
`ifndef ARB_FIXED_PRIORITY_EN
        r_last_grant <= w_grant_idx;
`endif
      end else if ((r_state == ST_SEND) && s_arready) begin
        r_arvalid <= 1'b0;
      end
    end
  end

  assign s_arid    = r_arid;
  assign s_arpay   = r_arpay;
  assign s_arvalid = r_arvalid;

  // One-entry R buffer: fill only when empty, so a drained slot refills one cycle later.
  assign w_s_rhs = s_rvalid && !r_rfull;
  assign w_m_rhs = r_rfull && (r_rid[1] ? m1_rready : m0_rready);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_rfull <= 1'b0;
      r_rid   <= '0;
      r_rpay  <= '0;
    end else if (w_s_rhs) begin
      r_rfull <= 1'b1;
      r_rid   <= s_rid;
      r_rpay  <= s_rpay;
    end else if (w_m_rhs) begin
      r_rfull <= 1'b0;
    end
  end

  assign s_rready  = !r_rfull;
  assign m0_rvalid = r_rfull && !r_rid[1];
  assign m1_rvalid = r_rfull &&  r_rid[1];
  assign m0_rid    = r_rid[0];
  assign m1_rid    = r_rid[0];
  assign m0_rpay   = r_rpay;
  assign m1_rpay   = r_rpay;

  // Outstanding bursts: +1 on AR grant, -1 on the master's RLAST handshake
  assign w_inc0 = m0_arready;
  assign w_inc1 = m1_arready;
  assign w_dec0 = w_m_rhs && r_rpay[0] && !r_rid[1];
  assign w_dec1 = w_m_rhs && r_rpay[0] &&  r_rid[1];

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_cnt0 <= 4'd0;
      r_cnt1 <= 4'd0;
    end else begin
      r_cnt0 <= cnt_next(r_cnt0, w_inc0, w_dec0);
      r_cnt1 <= cnt_next(r_cnt1, w_inc1, w_dec1);
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter_2x1.sv
// Self-checking bench for axi_read_arbiter_2x1: directed test-plan steps, then randomized traffic
// against a transaction-level reference model (honours ARB_FIXED_PRIORITY_EN like the design).
module tb_axi_read_arbiter_2x1;

  localparam int BW  = 32;
  localparam int AW  = BW + 17;
  localparam int RW  = BW + 3;
  localparam int MAX = 4;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic          m0_arid, m1_arid;
  logic [AW-1:0] m0_arpay, m1_arpay;
  logic          m0_arvalid, m1_arvalid;
  logic          m0_arready, m1_arready;
  logic [1:0]    s_arid;
  logic [AW-1:0] s_arpay;
  logic          s_arvalid, s_arready;
  logic [1:0]    s_rid;
  logic [RW-1:0] s_rpay;
  logic          s_rvalid, s_rready;
  logic          m0_rid, m1_rid;
  logic [RW-1:0] m0_rpay, m1_rpay;
  logic          m0_rvalid, m1_rvalid;
  logic          m0_rready, m1_rready;

  axi_read_arbiter_2x1 #(.BUSWIDTH(BW), .MAX_OUTST(MAX)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .m0_arid(m0_arid), .m0_arpay(m0_arpay), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m1_arid(m1_arid), .m1_arpay(m1_arpay), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .s_arid(s_arid), .s_arpay(s_arpay), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rpay(s_rpay), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m0_rid(m0_rid), .m0_rpay(m0_rpay), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_rid(m1_rid), .m1_rpay(m1_rpay), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: pending slave request, per-master outstanding counts, buffered beat
  typedef struct { logic [1:0] id; int len; } burst_t;
  typedef struct { int mst; logic id; logic [RW-1:0] pay; } beat_t;

  bit            md_pending;
  logic [1:0]    md_arid;
  logic [AW-1:0] md_arpay;
  int            md_cnt[2];
  int            md_last;
  bit            md_rfull;
  logic [1:0]    md_rid;
  logic [RW-1:0] md_rpay;
  burst_t        sl_q[$];
  beat_t         dlv_q[$];
  bit            beat_taken;

  function automatic void model_reset();
    md_pending = 0; md_arid = '0; md_arpay = '0;
    md_cnt[0] = 0; md_cnt[1] = 0; md_last = 1;
    md_rfull = 0; md_rid = '0; md_rpay = '0;
    sl_q.delete();
    beat_taken = 0;
  endfunction

  function automatic int pick(bit e0, bit e1);
    if (!e0 && !e1) return -1;
    if (e0 && e1) begin
`ifdef ARB_FIXED_PRIORITY_EN
      return 0;
`else
      return (md_last == 0) ? 1 : 0;
`endif
    end
    return e0 ? 0 : 1;
  endfunction

  // Compare every DUT output with the model, then advance the model across the coming edge.
  task automatic model_step();
    bit e0, e1;
    int w, take_m;
    bit inc[2], dec[2];
    e0 = !md_pending && !ARESET && m0_arvalid && (md_cnt[0] < MAX);
    e1 = !md_pending && !ARESET && m1_arvalid && (md_cnt[1] < MAX);
    w  = pick(e0, e1);
    check("m0_arready", 64'(m0_arready), 64'(w == 0));
    check("m1_arready", 64'(m1_arready), 64'(w == 1));
    check("s_arvalid",  64'(s_arvalid),  64'(md_pending));
    check("s_arid",     64'(s_arid),     64'(md_arid));
    check("s_arpay",    64'(s_arpay),    64'(md_arpay));
    check("s_rready",   64'(s_rready),   64'(!md_rfull));
    check("m_rvalid",   64'({m1_rvalid, m0_rvalid}),
          64'(md_rfull ? (md_rid[1] ? 2'b10 : 2'b01) : 2'b00));
    check("m_rid",      64'({m1_rid, m0_rid}), 64'({2{md_rid[0]}}));
    check("m0_rpay",    64'(m0_rpay),    64'(md_rpay));
    check("m1_rpay",    64'(m1_rpay),    64'(md_rpay));
    if (ARESET) begin
      model_reset();
      return;
    end
    take_m = -1;
    if (md_rfull && (md_rid[1] ? m1_rready : m0_rready)) take_m = int'(md_rid[1]);
    if (take_m == 0) dlv_q.push_back('{0, m0_rid, m0_rpay});
    if (take_m == 1) dlv_q.push_back('{1, m1_rid, m1_rpay});
    beat_taken = !md_rfull && s_rvalid;
    inc[0] = (w == 0); inc[1] = (w == 1);
    dec[0] = (take_m == 0) && md_rpay[0];
    dec[1] = (take_m == 1) && md_rpay[0];
    for (int i = 0; i < 2; i++) begin
      if (inc[i] && !dec[i]) md_cnt[i]++;
      else if (dec[i] && !inc[i] && md_cnt[i] > 0) md_cnt[i]--;
    end
    if (md_pending && s_arready) begin
      sl_q.push_back('{md_arid, int'(md_arpay[16:13])});
      md_pending = 0;
    end
    if (w >= 0) begin
      md_pending = 1;
      md_arid  = {w[0], (w == 1) ? m1_arid : m0_arid};
      md_arpay = (w == 1) ? m1_arpay : m0_arpay;
      md_last  = w;
    end
    if (beat_taken) begin
      md_rfull = 1; md_rid = s_rid; md_rpay = s_rpay;
    end else if (take_m >= 0) begin
      md_rfull = 0;
    end
  endtask

  task automatic tick();
    @(negedge ACLK);
    model_step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [AW-1:0] mk_ar(input logic [BW-1:0] addr, input logic [3:0] len);
    return {addr, len, 13'h0};
  endfunction

  task automatic idle_inputs();
    m0_arvalid = 0; m1_arvalid = 0; m0_arid = 0; m1_arid = 0;
    m0_arpay = '0; m1_arpay = '0; s_arready = 0;
    s_rvalid = 0; s_rid = '0; s_rpay = '0;
    m0_rready = 0; m1_rready = 0;
  endtask

  task automatic do_reset(input int n);
    idle_inputs();
    ARESET = 1;
    repeat (n) tick();
    ARESET = 0;
    dlv_q.delete();
  endtask

  // Present one slave beat and hold it until the buffer accepts it.
  task automatic send_beat(input logic [1:0] rid, input logic [RW-1:0] pay);
    bit taken;
    taken = 0;
    s_rvalid = 1; s_rid = rid; s_rpay = pay;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (beat_taken) begin
        taken = 1;
        break;
      end
    end
    check("beat_accept_timeout", 64'(taken), 64'd1);
    s_rvalid = 0;
  endtask

  bit            sl_active, sl_hold, got, done;
  logic [1:0]    sl_id;
  int            sl_left;
  int            g;
  burst_t        b;

  initial begin
    model_reset();
    idle_inputs();
    ARESET = 1;
    @(posedge ACLK);
    #1;
    do_reset(2);

    // Reset state
    settle();
    check("rst_s_arvalid", 64'(s_arvalid), 64'd0);
    check("rst_s_arid",    64'(s_arid),    64'd0);
    check("rst_m_rvalid",  64'({m1_rvalid, m0_rvalid}), 64'd0);
    check("rst_s_rready",  64'(s_rready),  64'd1);

    // Single request
    m0_arvalid = 1; m0_arid = 1; m0_arpay = mk_ar(32'h100, 4'd3);
    settle();
    check("single_m0_arready", 64'(m0_arready), 64'd1);
    tick();
    m0_arvalid = 0; s_arready = 1;
    settle();
    check("single_s_arvalid", 64'(s_arvalid), 64'd1);
    check("single_s_arid",    64'(s_arid),    64'h1);
    check("single_addr",      64'(s_arpay[48:17]), 64'h100);
    check("single_len",       64'(s_arpay[16:13]), 64'd3);
    tick();
    s_arready = 0;
    settle();
    check("single_back_idle", 64'(s_arvalid), 64'd0);
    tick();

    // Contention: one grant every 2 cycles, alternating (or all m0 with fixed priority)
    do_reset(1);
    m0_arvalid = 1; m1_arvalid = 1; m0_arid = 0; m1_arid = 1;
    m0_arpay = mk_ar(32'h1000, 4'd0); m1_arpay = mk_ar(32'h2000, 4'd0);
    s_arready = 1;
    for (int k = 0; k < 8; k++) begin
      settle();
      if (k % 2 == 0) begin
`ifdef ARB_FIXED_PRIORITY_EN
        g = 0;
`else
        g = (k / 2) % 2;
`endif
        check("cont_grant", 64'({m1_arready, m0_arready}), (g == 1) ? 64'h2 : 64'h1);
      end else begin
        check("cont_gap", 64'({m1_arready, m0_arready}), 64'h0);
      end
      tick();
    end

    // Routing: 4 beats with RID=2'b11 all go to master 1 in order
    do_reset(1);
    m1_arvalid = 1; m1_arid = 1; m1_arpay = mk_ar(32'h300, 4'd3); s_arready = 1;
    tick();
    m1_arvalid = 0;
    tick();
    s_arready = 0; m1_rready = 1; m0_rready = 0;
    dlv_q.delete();
    for (int i = 0; i < 4; i++) send_beat(2'b11, {32'hA0 + 32'(i), 2'b00, (i == 3)});
    repeat (3) tick();
    check("route_count", 64'(dlv_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < dlv_q.size(); i++) begin
      check("route_master", 64'(dlv_q[i].mst), 64'd1);
      check("route_rid",    64'(dlv_q[i].id),  64'd1);
      check("route_data",   64'(dlv_q[i].pay), 64'({32'hA0 + 32'(i), 2'b00, (i == 3)}));
    end

    // Backpressure: buffer full, master stalls 5 cycles, slave beat waits
    do_reset(1);
    m0_arvalid = 1; m0_arid = 0; m0_arpay = mk_ar(32'h400, 4'd1); s_arready = 1;
    tick();
    m0_arvalid = 0;
    tick();
    s_arready = 0; m0_rready = 0;
    dlv_q.delete();
    send_beat(2'b00, {32'hB0, 2'b10, 1'b0});
    s_rvalid = 1; s_rid = 2'b00; s_rpay = {32'hB1, 2'b01, 1'b1};
    for (int k = 0; k < 5; k++) begin
      settle();
      check("bp_s_rready",  64'(s_rready),  64'd0);
      check("bp_m0_rvalid", 64'(m0_rvalid), 64'd1);
      tick();
    end
    m0_rready = 1;
    got = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (beat_taken) begin
        got = 1;
        break;
      end
    end
    check("bp_second_accepted", 64'(got), 64'd1);
    s_rvalid = 0;
    repeat (3) tick();
    check("bp_count", 64'(dlv_q.size()), 64'd2);
    if (dlv_q.size() == 2) begin
      check("bp_beat0", 64'(dlv_q[0].pay), 64'({32'hB0, 2'b10, 1'b0}));
      check("bp_beat1", 64'(dlv_q[1].pay), 64'({32'hB1, 2'b01, 1'b1}));
    end

    // Outstanding limit: 4 m0 bursts, the 5th waits while m1 still gets through
    do_reset(1);
    m0_arvalid = 1; m0_arid = 0; m0_arpay = mk_ar(32'h500, 4'd0); s_arready = 1;
    repeat (8) tick();
    m1_arvalid = 1; m1_arid = 0; m1_arpay = mk_ar(32'h600, 4'd0);
    settle();
    check("lim_m0_blocked", 64'(m0_arready), 64'd0);
    check("lim_m1_granted", 64'(m1_arready), 64'd1);
    tick();
    m1_arvalid = 0;
    tick();
    settle();
    check("lim_m0_still_blocked", 64'(m0_arready), 64'd0);
    m0_rready = 1;
    send_beat(2'b00, {32'hC0, 2'b00, 1'b1});
    got = 0;
    for (int t = 0; t < 6; t++) begin
      settle();
      if (m0_arready) begin
        got = 1;
        break;
      end
      tick();
    end
    check("lim_m0_regranted", 64'(got), 64'd1);
    tick();

    // Reset in SEND with a full R buffer
    do_reset(1);
    m0_arvalid = 1; m0_arid = 1; m0_arpay = mk_ar(32'h700, 4'd0);
    tick();
    m0_arvalid = 0;
    send_beat(2'b10, {32'hD0, 2'b00, 1'b1});
    settle();
    check("pre_rst_s_arvalid", 64'(s_arvalid), 64'd1);
    check("pre_rst_m1_rvalid", 64'(m1_rvalid), 64'd1);
    ARESET = 1;
    tick();
    ARESET = 0;
    settle();
    check("post_rst_s_arvalid", 64'(s_arvalid), 64'd0);
    check("post_rst_m_rvalid",  64'({m1_rvalid, m0_rvalid}), 64'd0);
    check("post_rst_s_rready",  64'(s_rready), 64'd1);
    m0_arvalid = 1; m1_arvalid = 1;
    settle();
    check("post_rst_tie_m0", 64'({m1_arready, m0_arready}), 64'h1);
    tick();

    // Randomized traffic against the model
    do_reset(1);
    sl_active = 0; sl_hold = 0; sl_left = 0; sl_id = '0;
    for (int c = 0; c < 3000; c++) begin
      m0_arvalid = ($urandom_range(0, 2) != 0);
      m1_arvalid = ($urandom_range(0, 2) != 0);
      m0_arid = 1'($urandom()); m1_arid = 1'($urandom());
      m0_arpay = {$urandom(), 4'($urandom_range(0, 3)), 13'($urandom())};
      m1_arpay = {$urandom(), 4'($urandom_range(0, 3)), 13'($urandom())};
      s_arready = ($urandom_range(0, 3) != 0);
      m0_rready = ($urandom_range(0, 9) < 7);
      m1_rready = ($urandom_range(0, 9) < 7);
      if (!sl_hold) begin
        s_rvalid = 0;
        if (!sl_active && sl_q.size() > 0) begin
          b = sl_q.pop_front();
          sl_active = 1; sl_id = b.id; sl_left = b.len + 1;
        end
        if (sl_active && $urandom_range(0, 3) != 0) begin
          s_rvalid = 1; s_rid = sl_id;
          s_rpay = {$urandom(), 2'($urandom()), (sl_left == 1)};
          sl_hold = 1;
        end
      end
      tick();
      if (sl_hold && beat_taken) begin
        sl_hold = 0;
        sl_left--;
        if (sl_left == 0) sl_active = 0;
        s_rvalid = 0;
      end
    end

    // Drain every outstanding burst
    m0_arvalid = 0; m1_arvalid = 0; s_arready = 1; m0_rready = 1; m1_rready = 1;
    done = 0;
    for (int c = 0; c < 500; c++) begin
      if (!sl_hold) begin
        s_rvalid = 0;
        if (!sl_active && sl_q.size() > 0) begin
          b = sl_q.pop_front();
          sl_active = 1; sl_id = b.id; sl_left = b.len + 1;
        end
        if (sl_active) begin
          s_rvalid = 1; s_rid = sl_id;
          s_rpay = {$urandom(), 2'($urandom()), (sl_left == 1)};
          sl_hold = 1;
        end
      end
      tick();
      if (sl_hold && beat_taken) begin
        sl_hold = 0;
        sl_left--;
        if (sl_left == 0) sl_active = 0;
        s_rvalid = 0;
      end
      if (!sl_active && !sl_hold && sl_q.size() == 0 && !md_pending && !md_rfull) begin
        done = 1;
        break;
      end
    end
    check("drain_complete", 64'(done), 64'd1);

    // With everything returned, both masters can again issue a full quota
    m0_arvalid = 1; m1_arvalid = 1; s_arready = 1;
    repeat (16) tick();
    m0_arvalid = 0; m1_arvalid = 0;
    tick();
    settle();
    check("final_idle", 64'(s_arvalid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
